// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard/memory handshake and stage-control bundle
interface pipeline_hazard_ctrl_if;
  logic load_use;
  logic br_taken;
  logic imem_req;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic pc_we;
  logic if_id_we;
  logic id_ex_we;
  logic ex_mem_we;
  logic mem_wb_we;
  logic id_ex_bubble;
  logic if_id_flush;
  logic id_ex_flush;

  modport master (
    output load_use, br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  id_ex_bubble, if_id_flush, id_ex_flush
  );

  modport slave (
    input  load_use, br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output id_ex_bubble, if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// The FSM state is the outstanding-transaction record; freeze releases in the response cycle.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DMEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic                 err_protocol_o,
  output logic                 err_timeout_o
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    I_WAIT  = 2'b01,
    D_WAIT  = 2'b10,
    ID_WAIT = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              err_protocol_q, err_protocol_d;
  logic              err_timeout_q, err_timeout_d;

  logic imem_out, dmem_out;
  logic imem_out_d, dmem_out_d;
  logic freeze;

  assign imem_out = (state_q == I_WAIT) || (state_q == ID_WAIT);
  assign dmem_out = (state_q == D_WAIT) || (state_q == ID_WAIT);
  assign freeze   = (imem_out && !bus.imem_resp) || (dmem_out && !bus.dmem_resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cnt_q    <= '0;
      bubble_cnt_q   <= '0;
      flush_cnt_q    <= '0;
      tmo_q          <= '0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      bubble_cnt_q   <= bubble_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      tmo_q          <= tmo_d;
      err_protocol_q <= err_protocol_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    tmo_d          = '0;
    err_protocol_d = err_protocol_q;
    err_timeout_d  = err_timeout_q;
    imem_out_d     = imem_out;
    dmem_out_d     = dmem_out;

    bus.pc_we        = 1'b0;
    bus.if_id_we     = 1'b0;
    bus.id_ex_we     = 1'b0;
    bus.ex_mem_we    = 1'b0;
    bus.mem_wb_we    = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;

    // A response always retires its flag; a request only opens one if it was not answered at once.
    if (bus.imem_resp) begin
      imem_out_d = 1'b0;
    end else if (bus.imem_req) begin
      imem_out_d = 1'b1;
    end
    if (bus.dmem_resp) begin
      dmem_out_d = 1'b0;
    end else if (bus.dmem_req) begin
      dmem_out_d = 1'b1;
    end

    if ((bus.imem_resp && !imem_out && !bus.imem_req) ||
        (bus.dmem_resp && !dmem_out && !bus.dmem_req)) begin
      err_protocol_d = 1'b1;
    end

    case ({dmem_out_d, imem_out_d})
      2'b00:   state_d = RUN;
      2'b01:   state_d = I_WAIT;
      2'b10:   state_d = D_WAIT;
      default: state_d = ID_WAIT;
    endcase

    if (dmem_out) begin
      tmo_d = tmo_q + 32'd1;
      if ((DMEM_TIMEOUT != 0) && (tmo_d == 32'(DMEM_TIMEOUT))) begin
        err_timeout_d = 1'b1;
      end
    end

    if (rst_n) begin
      if (freeze) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end else if (bus.br_taken) begin
        bus.pc_we       = 1'b1;
        bus.if_id_we    = 1'b1;
        bus.id_ex_we    = 1'b1;
        bus.ex_mem_we   = 1'b1;
        bus.mem_wb_we   = 1'b1;
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
        flush_cnt_d     = flush_cnt_q + 1'b1;
      end else if (bus.load_use) begin
        bus.id_ex_we     = 1'b1;
        bus.ex_mem_we    = 1'b1;
        bus.mem_wb_we    = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bubble_cnt_d     = bubble_cnt_q + 1'b1;
      end else begin
        bus.pc_we     = 1'b1;
        bus.if_id_we  = 1'b1;
        bus.id_ex_we  = 1'b1;
        bus.ex_mem_we = 1'b1;
        bus.mem_wb_we = 1'b1;
      end
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign bubble_cnt_o   = bubble_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
  assign err_protocol_o = err_protocol_q;
  assign err_timeout_o  = err_timeout_q;

endmodule
